// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch front end: default widths, fetch FSM
// encoding and the {pc, inst} entry carried from memory to decode.
package instruction_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned INST_W_DEF = 16;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StReq  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Small synchronous prefetch FIFO with flush and a registered head entry, so the
// head data/valid seen by decode come straight from flops.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             do_push, do_pop, remain_empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head_data  = head_q;
    assign head_valid = valid_q;

    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    // Nothing left once this cycle's pop is taken: a push becomes the new head directly.
    assign remain_empty = empty | ((count_q == CNT_W'(1)) & do_pop);

    // Pointer/count next state; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Next head entry; zero whenever the FIFO will be empty.
    always_comb begin
        head_d = '0;
        if (count_d != '0) begin
            head_d = (do_push && remain_empty) ? push_data : mem_q[rd_ptr_d];
        end
    end

    // Control state and registered head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
        end
    end

    // Entry storage; contents are only ever read behind a valid count.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one read at a time to the memory hierarchy,
// buffers returned words and presents {pc, inst} to decode. A redirect during an
// outstanding read lets that read finish (address held) and drops its data.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       INST_W     = INST_W_DEF,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_rd_ready,
    input  logic [INST_W-1:0] mem_inst
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    fetch_state_e             state_q;
    logic [ADDR_W-1:0]        pc_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     rd_en_q;
    logic                     discard_q;

    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full, fifo_empty, head_valid;
    logic [ADDR_W+INST_W-1:0] head_data;
    logic                     push, pop, can_issue;

    // Only one read is ever outstanding, so the count alone bounds the FIFO.
    assign can_issue = fetch_enable & ~redirect_valid & (fifo_count < CNT_W'(FIFO_DEPTH));
    // The full term never fires given the issue rule; it keeps the FIFO safe regardless.
    assign push = (state_q == StReq) & mem_rd_ready & ~discard_q & ~redirect_valid & ~fifo_full;
    assign pop  = out_ready & ~fifo_empty & ~redirect_valid;

    assign out_valid       = head_valid & ~redirect_valid;
    assign out_pc          = head_data[ADDR_W+INST_W-1:INST_W];
    assign out_inst        = head_data[INST_W-1:0];
    assign mem_read_enable = rd_en_q;
    assign mem_address     = addr_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  ({pc_q, mem_inst}),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Fetch FSM with PC, discard flag and registered memory request outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            rd_en_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (can_issue) begin
                        state_q <= StReq;
                        rd_en_q <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                StReq: begin
                    if (mem_rd_ready) begin
                        state_q   <= StIdle;
                        rd_en_q   <= 1'b0;
                        discard_q <= 1'b0;
                        if (redirect_valid) begin
                            pc_q <= redirect_pc;
                        end else if (!discard_q) begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end else if (redirect_valid) begin
                        // Read stays on the bus until it completes; its data is dropped.
                        pc_q      <= redirect_pc;
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
